// File: rtl/circle_ctrl_if.sv
`default_nettype none
// ============================================================================
// circle_ctrl_if : keypad, timebase and VGA pixel bus of the circle controller
// Rev 1.0
// ============================================================================
interface circle_ctrl_if;
   logic        tick;
   logic [4:0]  key_code;
   logic        key_ready;
   logic [9:0]  col_addr;
   logic [8:0]  row_addr;
   logic [9:0]  x;
   logic [8:0]  y;
   logic [9:0]  radius;
   logic        cmd_pulse;
   logic [11:0] pixel_data;

   modport master (
      output tick, key_code, key_ready, col_addr, row_addr,
      input  x, y, radius, cmd_pulse, pixel_data
   );

   modport slave (
      input  tick, key_code, key_ready, col_addr, row_addr,
      output x, y, radius, cmd_pulse, pixel_data
   );
endinterface
`default_nettype wire

// File: rtl/circle_ctrl.sv
`default_nettype none
// ============================================================================
// circle_ctrl : keypad-driven circle move/resize with hold-to-repeat and a
//               2-stage pixel hit test.  Rev 1.0
// ============================================================================
module circle_ctrl #(
   parameter int          H_RES         = 640,
   parameter int          V_RES         = 480,
   parameter int          X_INIT        = 320,
   parameter int          Y_INIT        = 240,
   parameter int          R_INIT        = 15,
   parameter int          R_MIN         = 5,
   parameter int          R_MAX         = 200,
   parameter int          STEP_XY       = 20,
   parameter int          STEP_R        = 5,
   parameter int          REPEAT_DELAY  = 500,
   parameter int          REPEAT_PERIOD = 100,
   parameter logic [11:0] FG            = 12'h0F0,
   parameter logic [11:0] BG            = 12'hFFF
) (
   input  logic         clk,
   input  logic         rstn,
   circle_ctrl_if.slave bus
);

   localparam logic signed [11:0] C_STEP_XY = 12'(STEP_XY);
   localparam logic signed [11:0] C_STEP_R  = 12'(STEP_R);
   localparam logic signed [11:0] C_X_MAX   = 12'(H_RES - 1);
   localparam logic signed [11:0] C_Y_MAX   = 12'(V_RES - 1);
   localparam logic signed [11:0] C_R_MIN   = 12'(R_MIN);
   localparam logic signed [11:0] C_R_MAX   = 12'(R_MAX);
   localparam logic [15:0]        C_DELAY_LAST  = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0]        C_PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t             r_state, w_state_next;
   logic               r_key_q;
   logic [4:0]         r_code, w_code_next;
   logic [15:0]        r_cnt, w_cnt_next, w_cnt_limit;
   logic               w_press, w_apply;
   logic [4:0]         w_apply_code;
   logic [9:0]         r_x;
   logic [8:0]         r_y;
   logic [9:0]         r_radius;
   logic               r_cmd_pulse;
   logic signed [11:0] w_x_step, w_y_step, w_r_step;
   logic [9:0]         w_dx, w_dy, r_dx, r_dy;
   logic [19:0]        r_r_sq;
   logic [20:0]        w_dist_sq;
   logic [11:0]        r_pixel;

   function automatic logic is_mapped(input logic [4:0] code);
      return code inside {5'h0C, 5'h0E, 5'h09, 5'h11, 5'h10, 5'h12};
   endfunction

   function automatic logic signed [11:0] sat(input logic signed [11:0] v,
                                              input logic signed [11:0] lo,
                                              input logic signed [11:0] hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   assign w_press     = bus.key_ready & ~r_key_q;
   assign w_cnt_limit = (r_state == S_HOLD) ? C_DELAY_LAST : C_PERIOD_LAST;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_apply      = 1'b0;
      w_apply_code = r_code;
      w_code_next  = r_code;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_press) begin
               if (is_mapped(bus.key_code)) begin
                  w_apply      = 1'b1;
                  w_apply_code = bus.key_code;
                  w_code_next  = bus.key_code;
                  w_cnt_next   = '0;
                  w_state_next = S_HOLD;
               end else begin
                  w_state_next = S_WAIT;
               end
            end
         end
         S_HOLD, S_REPEAT: begin
            if (!bus.key_ready) begin
               w_state_next = S_IDLE;
            end else if (bus.key_code != r_code) begin
               // A different key under a continuous hold restarts the timing
               w_code_next = bus.key_code;
               w_cnt_next  = '0;
               if (is_mapped(bus.key_code)) begin
                  w_apply      = 1'b1;
                  w_apply_code = bus.key_code;
                  w_state_next = S_HOLD;
               end else begin
                  w_state_next = S_WAIT;
               end
            end else if (bus.tick) begin
               if (r_cnt == w_cnt_limit) begin
                  w_apply      = 1'b1;
                  w_cnt_next   = '0;
                  w_state_next = S_REPEAT;
               end else begin
                  w_cnt_next = r_cnt + 16'd1;
               end
            end
         end
         S_WAIT: begin
            if (!bus.key_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_x_step = '0;
      w_y_step = '0;
      w_r_step = '0;
      case (w_apply_code)
         5'h0C:   w_x_step = -C_STEP_XY;
         5'h0E:   w_x_step =  C_STEP_XY;
         5'h09:   w_y_step = -C_STEP_XY;
         5'h11:   w_y_step =  C_STEP_XY;
         5'h10:   w_r_step = -C_STEP_R;
         5'h12:   w_r_step =  C_STEP_R;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_key_q     <= 1'b0;
         r_code      <= '0;
         r_cnt       <= '0;
         r_x         <= 10'(X_INIT);
         r_y         <= 9'(Y_INIT);
         r_radius    <= 10'(R_INIT);
         r_cmd_pulse <= 1'b0;
      end else begin
         r_key_q     <= bus.key_ready;
         r_code      <= w_code_next;
         r_cnt       <= w_cnt_next;
         r_cmd_pulse <= w_apply;
         if (w_apply) begin
            r_x      <= 10'(sat($signed({2'b00, r_x}) + w_x_step, 12'sd0, C_X_MAX));
            r_y      <= 9'(sat($signed({3'b000, r_y}) + w_y_step, 12'sd0, C_Y_MAX));
            r_radius <= 10'(sat($signed({2'b00, r_radius}) + w_r_step, C_R_MIN, C_R_MAX));
         end
      end
   end

   // Pixel hit test runs every clock against the currently registered circle
   always_comb begin
      w_dx = (bus.col_addr >= r_x) ? bus.col_addr - r_x : r_x - bus.col_addr;
      w_dy = {1'b0, ((bus.row_addr >= r_y) ? bus.row_addr - r_y : r_y - bus.row_addr)};
      w_dist_sq = 21'(r_dx) * 21'(r_dx) + 21'(r_dy) * 21'(r_dy);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_dx    <= '0;
         r_dy    <= '0;
         r_r_sq  <= '0;
         r_pixel <= BG;
      end else begin
         r_dx    <= w_dx;
         r_dy    <= w_dy;
         r_r_sq  <= 20'(r_radius) * 20'(r_radius);
         r_pixel <= (w_dist_sq <= {1'b0, r_r_sq}) ? FG : BG;
      end
   end

   assign bus.x          = r_x;
   assign bus.y          = r_y;
   assign bus.radius     = r_radius;
   assign bus.cmd_pulse  = r_cmd_pulse;
   assign bus.pixel_data = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_circle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_circle_ctrl : scoreboard bench for circle_ctrl commands and pixel output
// Rev 1.0
// ============================================================================
module tb_circle_ctrl;

   localparam int REPEAT_DELAY  = 500;
   localparam int REPEAT_PERIOD = 100;

   typedef struct { int x; int y; int r; } exp_t;
   typedef struct { int pix; longint due; } pix_t;

   logic clk;
   logic rstn;
   circle_ctrl_if bus ();

   circle_ctrl dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_errors = 0;
   int     pulses   = 0;
   longint pos_cnt  = 0;
   int     m_x, m_y, m_r;
   exp_t   exp_q[$];
   pix_t   pix_q[$];

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic void model_reset();
      m_x = 320; m_y = 240; m_r = 15;
   endfunction

   function automatic void model_cmd(input logic [4:0] code);
      bit hit;
      hit = 1'b1;
      case (code)
         5'h0C:   m_x = clampi(m_x - 20, 0, 639);
         5'h0E:   m_x = clampi(m_x + 20, 0, 639);
         5'h09:   m_y = clampi(m_y - 20, 0, 479);
         5'h11:   m_y = clampi(m_y + 20, 0, 479);
         5'h10:   m_r = clampi(m_r - 5, 5, 200);
         5'h12:   m_r = clampi(m_r + 5, 5, 200);
         default: hit = 1'b0;
      endcase
      if (hit) exp_q.push_back('{m_x, m_y, m_r});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) pos_cnt <= pos_cnt + 1;

   always @(negedge clk) begin
      if (rstn) begin
         if (bus.cmd_pulse) begin
            pulses++;
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("x", bus.x, e.x);
               check("y", bus.y, e.y);
               check("radius", bus.radius, e.r);
            end
         end
         if (pix_q.size() > 0 && pix_q[0].due <= pos_cnt) begin
            pix_t p;
            p = pix_q.pop_front();
            check("pixel", bus.pixel_data, p.pix);
         end
      end
   end

   task automatic pix(input int col, input int row);
      int d2, e;
      bus.col_addr = 10'(col);
      bus.row_addr = 9'(row);
      d2 = (col - m_x) * (col - m_x) + (row - m_y) * (row - m_y);
      e  = (d2 <= m_r * m_r) ? 32'h0F0 : 32'hFFF;
      pix_q.push_back('{e, pos_cnt + 2});
      cyc();
   endtask

   task automatic press(input logic [4:0] code);
      bus.key_code  = code;
      bus.key_ready = 1'b1;
      model_cmd(code);
      cyc(); cyc();
      bus.key_ready = 1'b0;
      cyc(); cyc();
   endtask

   task automatic hold_ticks(input int n, input logic [4:0] code);
      for (int k = 1; k <= n; k++) begin
         bit due;
         due = (k == REPEAT_DELAY) ||
               (k > REPEAT_DELAY && (k - REPEAT_DELAY) % REPEAT_PERIOD == 0);
         if (due) model_cmd(code);
         bus.tick = 1'b1; cyc();
         bus.tick = 1'b0; cyc();
         if (due) check("repeat_timing", exp_q.size(), 0);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rstn = 1'b0;
      bus.tick = 1'b0; bus.key_code = '0; bus.key_ready = 1'b0;
      bus.col_addr = '0; bus.row_addr = '0;
      model_reset();
      cyc(); cyc();
      check("rst_x", bus.x, 320);
      check("rst_y", bus.y, 240);
      check("rst_radius", bus.radius, 15);
      check("rst_pulse", bus.cmd_pulse, 0);
      check("rst_pixel", bus.pixel_data, 32'hFFF);
      rstn = 1'b1;
      cyc(); cyc();

      pix(320, 240); pix(336, 240); pix(335, 240); pix(320, 255); pix(320, 256);
      cyc(); cyc(); cyc();

      // single press
      p0 = pulses;
      press(5'h0E);
      repeat (6) cyc();
      check("press_x", bus.x, 340);
      check("press_pulses", pulses - p0, 1);

      // hold for repeats
      p0 = pulses;
      bus.key_code = 5'h12; bus.key_ready = 1'b1;
      model_cmd(5'h12);
      cyc();
      hold_ticks(720, 5'h12);
      bus.key_ready = 1'b0;
      cyc(); cyc();
      check("hold_radius", bus.radius, 35);
      check("hold_pulses", pulses - p0, 4);

      // saturation at every edge
      for (int i = 0; i < 20; i++) press(5'h0C);
      check("x_min", bus.x, 0);
      for (int i = 0; i < 35; i++) press(5'h0E);
      check("x_max", bus.x, 639);
      for (int i = 0; i < 14; i++) press(5'h09);
      check("y_min", bus.y, 0);
      for (int i = 0; i < 26; i++) press(5'h11);
      check("y_max", bus.y, 479);
      for (int i = 0; i < 40; i++) press(5'h12);
      check("r_max", bus.radius, 200);
      for (int i = 0; i < 42; i++) press(5'h10);
      check("r_min", bus.radius, 5);

      // key change mid-hold restarts timing
      bus.key_code = 5'h0C; bus.key_ready = 1'b1;
      model_cmd(5'h0C);
      cyc();
      hold_ticks(50, 5'h0C);
      bus.key_code = 5'h09;
      model_cmd(5'h09);
      cyc(); cyc();
      check("change_applied", exp_q.size(), 0);
      check("change_y", bus.y, 459);
      hold_ticks(520, 5'h09);
      bus.key_ready = 1'b0;
      cyc(); cyc();

      // unmapped code, from idle and mid-hold
      p0 = pulses;
      bus.key_code = 5'h01; bus.key_ready = 1'b1;
      cyc();
      hold_ticks(600, 5'h01);
      bus.key_ready = 1'b0;
      cyc(); cyc();
      check("unmapped_pulses", pulses - p0, 0);
      bus.key_code = 5'h0E; bus.key_ready = 1'b1;
      model_cmd(5'h0E);
      cyc(); cyc();
      p0 = pulses;
      bus.key_code = 5'h01;
      hold_ticks(600, 5'h01);
      bus.key_ready = 1'b0;
      cyc(); cyc();
      check("to_wait_pulses", pulses - p0, 0);

      // async reset while repeating, key still held
      bus.key_code = 5'h12; bus.key_ready = 1'b1;
      model_cmd(5'h12);
      cyc();
      hold_ticks(550, 5'h12);
      #1;
      rstn = 1'b0;
      #1;
      check("arst_x", bus.x, 320);
      check("arst_y", bus.y, 240);
      check("arst_radius", bus.radius, 15);
      check("arst_pulse", bus.cmd_pulse, 0);
      model_reset();
      cyc(); cyc();
      model_cmd(5'h12);
      rstn = 1'b1;
      cyc(); cyc();
      check("arst_repress", exp_q.size(), 0);
      check("arst_radius_after", bus.radius, 20);
      bus.key_ready = 1'b0;
      cyc(); cyc(); cyc();

      // pixels against the new circle
      pix(340, 240); pix(341, 240); pix(332, 256); pix(333, 256); pix(300, 240);
      for (int i = 0; i < 20; i++)
         pix(m_x + $urandom_range(0, 50) - 25, m_y + $urandom_range(0, 50) - 25);
      cyc(); cyc(); cyc();

      check("exp_q_drained", exp_q.size(), 0);
      check("pix_q_drained", pix_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
